// File: rtl/dafx_axi_reg_master_if.sv
// AXI4 register-bus channel bundle (axi4_reg_if) shared by DAFX masters and slaves.
interface axi4_reg_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
) (
  input logic clk,
  input logic rst_n
);
  logic [3:0]          awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [3:0]          arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    input  clk, rst_n,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/dafx_axi_reg_master.sv
// Command-stream to AXI4 INCR burst initiator with per-command worst-response completion.
// Optional counters enabled by defining DAFX_AXI_MST_STATS_EN.
module dafx_axi_reg_master #(
  parameter int AXI_ADDR_WIDTH_P = 16,
  parameter int AXI_DATA_WIDTH_P = 64,
  parameter int AXI_ID_P         = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  axi4_reg_if.master                  cif,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH_P-1:0] cmd_addr,
  input  logic [7:0]                  cmd_len,
  input  logic [AXI_DATA_WIDTH_P-1:0] wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  output logic [AXI_DATA_WIDTH_P-1:0] rd_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic                        done,
  output logic [1:0]                  done_resp
`ifdef DAFX_AXI_MST_STATS_EN
  ,
  output logic [31:0]                 stat_wr_cmds,
  output logic [31:0]                 stat_rd_cmds,
  output logic [31:0]                 stat_err_cmds
`endif
);
  typedef enum logic [2:0] {IDLE_E, AW_E, W_E, B_E, AR_E, R_E} state_t;

  state_t                      state;
  logic [AXI_ADDR_WIDTH_P-1:0] addr;
  logic [7:0]                  len;
  logic [7:0]                  cnt;
  logic [1:0]                  resp;
  logic                        is_write;
  logic                        awvalid_q;
  logic                        arvalid_q;
  logic                        bready_q;
  logic                        w_fire;
  logic                        r_fire;
  logic [1:0]                  r_beat_resp;
  logic                        unused_if;

  // Numeric max orders DECERR > SLVERR > EXOKAY > OKAY.
  function automatic logic [1:0] merge_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign w_fire      = (state == W_E) && wr_valid && cif.wready;
  assign r_fire      = (state == R_E) && cif.rvalid && rd_ready;
  // rlast must coincide with the final counted beat; any disagreement is a slave fault.
  assign r_beat_resp = merge_resp(cif.rresp, (cif.rlast != (cnt == 8'd0)) ? 2'b10 : 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE_E;
      cmd_ready <= 1'b0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      done      <= 1'b0;
      done_resp <= 2'b00;
      cnt       <= 8'd0;
      resp      <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE_E: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            resp      <= 2'b00;
            done_resp <= 2'b00;
            if (cmd_write) begin
              awvalid_q <= 1'b1;
              state     <= AW_E;
            end else begin
              arvalid_q <= 1'b1;
              state     <= AR_E;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        AW_E: if (cif.awready) begin
          awvalid_q <= 1'b0;
          cnt       <= len;
          state     <= W_E;
        end
        W_E: if (w_fire) begin
          if (cnt == 8'd0) begin
            bready_q <= 1'b1;
            state    <= B_E;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        B_E: if (cif.bvalid) begin
          bready_q  <= 1'b0;
          done      <= 1'b1;
          done_resp <= merge_resp(resp, cif.bresp);
          state     <= IDLE_E;
        end
        AR_E: if (cif.arready) begin
          arvalid_q <= 1'b0;
          cnt       <= len;
          state     <= R_E;
        end
        R_E: if (r_fire) begin
          resp <= merge_resp(resp, r_beat_resp);
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          if (cif.rlast) begin
            done      <= 1'b1;
            done_resp <= merge_resp(resp, r_beat_resp);
            state     <= IDLE_E;
          end
        end
        default: state <= IDLE_E;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == IDLE_E) && cmd_valid && cmd_ready) begin
      addr     <= cmd_addr;
      len      <= cmd_len;
      is_write <= cmd_write;
    end
  end

  assign cif.awid    = 4'(AXI_ID_P);
  assign cif.awaddr  = addr;
  assign cif.awlen   = len;
  assign cif.awsize  = 3'($clog2(AXI_DATA_WIDTH_P / 8));
  assign cif.awburst = 2'b01;
  assign cif.awvalid = awvalid_q;
  assign cif.wdata   = wr_data;
  assign cif.wstrb   = '1;
  assign cif.wlast   = (cnt == 8'd0);
  assign cif.wvalid  = (state == W_E) && wr_valid;
  assign cif.bready  = bready_q;
  assign cif.arid    = 4'(AXI_ID_P);
  assign cif.araddr  = addr;
  assign cif.arlen   = len;
  assign cif.arsize  = 3'($clog2(AXI_DATA_WIDTH_P / 8));
  assign cif.arburst = 2'b01;
  assign cif.arvalid = arvalid_q;
  assign cif.rready  = (state == R_E) && rd_ready;

  assign wr_ready = (state == W_E) && cif.wready;
  assign rd_valid = (state == R_E) && cif.rvalid;
  assign rd_data  = cif.rdata;

  assign unused_if = cif.clk ^ cif.rst_n;

`ifdef DAFX_AXI_MST_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // is_write still describes the finished command while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wr_cmds  <= 32'd0;
      stat_rd_cmds  <= 32'd0;
      stat_err_cmds <= 32'd0;
    end else if (done) begin
      if (is_write) stat_wr_cmds <= sat_inc(stat_wr_cmds);
      else          stat_rd_cmds <= sat_inc(stat_rd_cmds);
      if (done_resp != 2'b00) stat_err_cmds <= sat_inc(stat_err_cmds);
    end
  end
`endif
endmodule

// File: tb/tb_dafx_axi_reg_master.sv
// Directed plus randomized bench for dafx_axi_reg_master with an in-bench AXI slave and reference model.
module tb_dafx_axi_reg_master;
  localparam int AW = 16;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst;
  logic rst_n;
  always #5 clk = ~clk;
  assign rst_n = ~rst;

  axi4_reg_if #(.ADDR_W(AW), .DATA_W(DW)) cif (.clk(clk), .rst_n(rst_n));

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [DW-1:0] wr_data, rd_data;
  logic          wr_valid, wr_ready, rd_valid, rd_ready, done;
  logic [1:0]    done_resp;
`ifdef DAFX_AXI_MST_STATS_EN
  logic [31:0]   stat_wr_cmds, stat_rd_cmds, stat_err_cmds;
`endif

  int total = 0;
  int bad   = 0;

  dafx_axi_reg_master #(.AXI_ADDR_WIDTH_P(AW), .AXI_DATA_WIDTH_P(DW), .AXI_ID_P(0)) dut (
    .clk(clk), .rst(rst), .cif(cif),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp)
`ifdef DAFX_AXI_MST_STATS_EN
    , .stat_wr_cmds(stat_wr_cmds), .stat_rd_cmds(stat_rd_cmds), .stat_err_cmds(stat_err_cmds)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic coin(input bit gaps);
    return gaps ? ($urandom_range(1, 0) == 1) : 1'b1;
  endfunction

  task automatic do_write(input logic [AW-1:0] a, input logic [7:0] l, input logic [1:0] br,
                          input bit gaps, input logic [DW-1:0] d0);
    logic [DW-1:0] data[$];
    logic [AW-1:0] pa;
    logic [7:0]    pl;
    int  w_n = 0, aw_n = 0, cyc = 0, acc_cyc = -1, aw_first = -1, hs_cyc = -1, done_cyc = -1, done_n = 0;
    bit  acc = 0, b_pend = 0, b_hs = 0, aw_prev = 0;
    data.push_back(d0);
    for (int i = 1; i <= int'(l); i++) data.push_back({$urandom, $urandom});
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = l;
    while (done_n == 0 && cyc < 5000) begin
      if (acc) cmd_valid = 1'b0;
      if (b_hs) begin cif.bvalid = 1'b0; b_hs = 0; end
      cif.awready = coin(gaps);
      cif.wready  = coin(gaps);
      wr_valid    = (w_n <= int'(l)) && coin(gaps);
      wr_data     = (w_n <= int'(l)) ? data[w_n] : '0;
      if (b_pend && !cif.bvalid && coin(gaps)) begin cif.bvalid = 1'b1; cif.bresp = br; end
      #1;
      if (cmd_valid && cmd_ready && !acc) begin acc = 1; acc_cyc = cyc; end
      if (cif.awvalid) begin
        if (aw_first < 0) aw_first = cyc;
        if (aw_prev) begin
          check("aw_addr_stable", cif.awaddr, pa);
          check("aw_len_stable", cif.awlen, pl);
        end
        if (cif.awready) begin
          aw_n++; aw_prev = 0;
          check("awaddr", cif.awaddr, a);
          check("awlen", cif.awlen, l);
          check("awsize_burst_id", {cif.awsize, cif.awburst, cif.awid}, {3'd3, 2'b01, 4'd0});
        end else begin
          aw_prev = 1; pa = cif.awaddr; pl = cif.awlen;
        end
      end
      if (cif.wvalid && cif.wready) begin
        check("w_bench_side_hs", wr_valid && wr_ready, 1);
        if (w_n > int'(l)) check("w_extra_beat", w_n, l);
        else begin
          check("wdata", cif.wdata, data[w_n]);
          check("wlast", cif.wlast, w_n == int'(l));
          check("wstrb", cif.wstrb, 8'hFF);
          if (w_n == int'(l)) b_pend = 1;
        end
        w_n++;
      end
      if (cif.bvalid && cif.bready) begin b_hs = 1; b_pend = 0; hs_cyc = cyc; end
      if (done) begin done_n++; done_cyc = cyc; end
      cyc++;
      if (done_n == 0) @(negedge clk);
    end
    check("wr_done_seen", done_n, 1);
    check("wr_done_resp", done_resp, br);
    check("wr_aw_count", aw_n, 1);
    check("wr_beats", w_n, int'(l) + 1);
    check("wr_accept_to_awvalid", aw_first, acc_cyc + 1);
    check("wr_bhs_to_done", done_cyc, hs_cyc + 1);
    @(negedge clk); #1;
    check("wr_done_pulse", done, 0);
    check("wr_next_cmd_ready", cmd_ready, 1);
    check("wr_done_resp_held", done_resp, br);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [7:0] l, input int last_at,
                         input int err_beat, input logic [1:0] err_code, input bit gaps,
                         input bit seq, input logic [DW-1:0] base);
    logic [DW-1:0] data[$];
    logic [1:0]    rr[$];
    logic [1:0]    exp = 2'b00;
    logic [AW-1:0] pa;
    logic [7:0]    pl;
    int  r_idx = 0, n_rx = 0, ar_n = 0, cyc = 0, acc_cyc = -1, ar_first = -1, hs_cyc = -1, done_cyc = -1, done_n = 0;
    bit  acc = 0, r_on = 0, r_hs = 0, ar_prev = 0;
    for (int i = 0; i <= last_at; i++) begin
      data.push_back(seq ? base + DW'(i) : {$urandom, $urandom});
      rr.push_back((i == err_beat) ? err_code : 2'b00);
      if (rr[i] > exp) exp = rr[i];
      if (((i == int'(l)) != (i == last_at)) && exp < 2'b10) exp = 2'b10;
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = l;
    while (done_n == 0 && cyc < 5000) begin
      if (acc) cmd_valid = 1'b0;
      if (r_hs) begin cif.rvalid = 1'b0; r_hs = 0; end
      cif.arready = coin(gaps);
      rd_ready    = coin(gaps);
      if (r_on && r_idx <= last_at && !cif.rvalid && coin(gaps)) begin
        cif.rvalid = 1'b1; cif.rdata = data[r_idx]; cif.rresp = rr[r_idx];
        cif.rlast  = (r_idx == last_at);
      end
      #1;
      if (cmd_valid && cmd_ready && !acc) begin acc = 1; acc_cyc = cyc; end
      if (cif.arvalid) begin
        if (ar_first < 0) ar_first = cyc;
        if (ar_prev) begin
          check("ar_addr_stable", cif.araddr, pa);
          check("ar_len_stable", cif.arlen, pl);
        end
        if (cif.arready) begin
          ar_n++; ar_prev = 0; r_on = 1;
          check("araddr", cif.araddr, a);
          check("arlen", cif.arlen, l);
          check("arsize_burst_id", {cif.arsize, cif.arburst, cif.arid}, {3'd3, 2'b01, 4'd0});
        end else begin
          ar_prev = 1; pa = cif.araddr; pl = cif.arlen;
        end
      end
      if (rd_valid && rd_ready) begin
        check("rd_rready_matches", cif.rready, 1);
        if (n_rx <= last_at) check("rd_data", rd_data, data[n_rx]);
        n_rx++;
      end
      if (cif.rvalid && cif.rready) begin r_hs = 1; r_idx++; hs_cyc = cyc; end
      if (done) begin done_n++; done_cyc = cyc; end
      cyc++;
      if (done_n == 0) @(negedge clk);
    end
    check("rd_done_seen", done_n, 1);
    check("rd_done_resp", done_resp, exp);
    check("rd_ar_count", ar_n, 1);
    check("rd_beats", n_rx, last_at + 1);
    check("rd_accept_to_arvalid", ar_first, acc_cyc + 1);
    check("rd_lasths_to_done", done_cyc, hs_cyc + 1);
    @(negedge clk); #1;
    check("rd_done_pulse", done, 0);
    check("rd_next_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    int  wn, cyc, quiet_done;
    bit  acc;
    logic [7:0] rl;
    rst = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 0; rd_ready = 0;
    cif.awready = 0; cif.wready = 0; cif.bvalid = 0; cif.bresp = 0;
    cif.arready = 0; cif.rvalid = 0; cif.rdata = '0; cif.rresp = 0; cif.rlast = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_valids", {cif.awvalid, cif.wvalid, cif.bready, cif.arvalid, cif.rready}, 5'b0);
    check("rst_done", done, 0);
    check("rst_done_resp", done_resp, 0);
    check("const_wstrb", cif.wstrb, 8'hFF);
    rst = 1'b0;

    do_write(16'h0010, 8'd0, 2'b00, 0, 64'h0000_0000_0000_1234);
    do_read(16'h0020, 8'd3, 3, -1, 2'b00, 0, 1, 64'hA0);
    do_write(16'hFF00, 8'd0, 2'b01, 0, 64'hDEAD_BEEF);
    do_read(16'h0028, 8'd3, 3, 2, 2'b10, 0, 1, 64'hB0);
    do_read(16'h0040, 8'd3, 1, -1, 2'b00, 0, 0, 64'h0);
    do_read(16'h0048, 8'd2, 3, -1, 2'b00, 0, 0, 64'h0);
    do_write(16'h0100, 8'd255, 2'b11, 0, 64'h1);
    do_read(16'h0200, 8'd255, 255, -1, 2'b00, 0, 0, 64'h0);

    for (int k = 0; k < 8; k++) begin
      rl = 8'($urandom_range(15, 0));
      if (k % 2 == 0)
        do_write(16'({$urandom_range(255, 0), 3'b000}), rl, 2'($urandom_range(3, 0)), 1, {$urandom, $urandom});
      else
        do_read(16'({$urandom_range(255, 0), 3'b000}), rl, int'(rl),
                int'($urandom_range(int'(rl) + 1, 0)) - 1, 2'($urandom_range(3, 0)), 1, 0, 64'h0);
    end

    // Reset during beat 2 of an 8-beat write burst.
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0300; cmd_len = 8'd7;
    cif.awready = 1; cif.wready = 1; wr_valid = 1; wr_data = 64'h5555;
    wn = 0; cyc = 0; acc = 0;
    while (wn < 2 && cyc < 100) begin
      #1;
      if (cmd_valid && cmd_ready) acc = 1;
      if (cif.wvalid && cif.wready) wn++;
      @(negedge clk);
      if (acc) cmd_valid = 0;
      cyc++;
    end
    #1;
    check("mid_burst_wvalid", cif.wvalid, 1);
    rst = 1'b1;
    @(negedge clk); #1;
    check("rst_mid_valids", {cif.awvalid, cif.wvalid, cif.bready, cif.arvalid, cif.rready}, 5'b0);
    check("rst_mid_done", done, 0);
    check("rst_mid_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    quiet_done = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (done) quiet_done++;
    end
    check("rst_mid_no_done", quiet_done, 0);
    check("rst_mid_idle", {cmd_ready, cif.wvalid}, 2'b10);
    wr_valid = 0;
    do_write(16'h0308, 8'd2, 2'b00, 0, 64'hCAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
